// File: rtl/out_buf_ctrl.sv
// out_buf_ctrl
// Circular-buffer controller for the output sample BRAM. Two producers share
// the single BRAM write port under round-robin arbitration: requester 0 is the
// SNN result writer and requester 1 is the trace/debug writer. Write addresses
// are word-aligned byte addresses that wrap at BRAM_MAX_ADDR. Occupancy is
// tracked against the host read pointer. Writers are held off while the buffer
// is full, and a registered interrupt flags occupancy at or above IRQ_THRESH.
//
// Ports
//   clk, resetn        clock (rising edge), async active-low reset
//   enable             when low, no new grants are issued
//   clear              synchronous flush of pointers, count and pending grant
//   req0/req1          write requests, held until the matching grant is seen
//   data0/data1        write data, stable while the matching req is high
//   gnt0/gnt1          one-cycle grant; the BRAM write happens in that cycle
//   bram_en/bram_we    BRAM port enable and byte write enables
//   bram_addr/bram_din BRAM byte address and write data
//   rd_ack             host consumed the word at rd_addr
//   rd_addr            byte address of the oldest unread word
//   count              occupancy in words
//   empty/full/irq     registered occupancy flags
module out_buf_ctrl #(
    parameter logic [31:0] BRAM_MAX_ADDR = 32'h0000_2000,
    parameter logic [31:0] IRQ_THRESH    = BRAM_MAX_ADDR / 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        clear,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_din,
    input  logic        rd_ack,
    output logic [31:0] rd_addr,
    output logic [15:0] count,
    output logic        empty,
    output logic        full,
    output logic        irq
);

    localparam logic [16:0] DEPTH = 17'(BRAM_MAX_ADDR >> 2);

    logic [31:0] wrPtr_q,    wrPtr_d;
    logic [31:0] rdAddr_q,   rdAddr_d;
    logic [15:0] count_q,    count_d;
    logic        gnt0_q,     gnt0_d;
    logic        gnt1_q,     gnt1_d;
    logic        lastWin1_q, lastWin1_d;
    logic [31:0] bramAddr_q, bramAddr_d;
    logic [31:0] bramDin_q,  bramDin_d;
    logic        empty_q,    empty_d;
    logic        full_q,     full_d;
    logic        irq_q,      irq_d;

    logic        writing;
    logic        ackEff;
    logic [16:0] occAfter;
    logic        roomOk;
    logic        elig0, elig1;
    logic        win0, win1;

    // Word-aligned step with wrap at the top of the buffer.
    function automatic logic [31:0] stepAddr(input logic [31:0] a);
        return (a >= BRAM_MAX_ADDR - 32'd4) ? 32'd0 : a + 32'd4;
    endfunction

    // The cycle after a registered grant is the write cycle itself.
    assign writing = gnt0_q | gnt1_q;
    // An ack against an empty buffer has nothing to consume.
    assign ackEff  = rd_ack & ~empty_q;
    // Occupancy once the current write and ack have landed. A new grant is
    // only safe if this still leaves a free word.
    assign occAfter = {1'b0, count_q} + {16'b0, writing} - {16'b0, ackEff};
    assign roomOk   = occAfter < DEPTH;

    // A requester's own live grant masks it so a still-high req is not
    // written twice.
    assign elig0 = req0 & ~gnt0_q & enable & ~clear & roomOk;
    assign elig1 = req1 & ~gnt1_q & enable & ~clear & roomOk;
    // On a tie, the requester that did not win last time goes first.
    assign win0  = elig0 & (~elig1 | lastWin1_q);
    assign win1  = elig1 & (~elig0 | ~lastWin1_q);

    always_comb begin
        wrPtr_d    = writing ? stepAddr(wrPtr_q) : wrPtr_q;
        rdAddr_d   = ackEff ? stepAddr(rdAddr_q) : rdAddr_q;
        count_d    = occAfter[15:0];
        gnt0_d     = win0;
        gnt1_d     = win1;
        lastWin1_d = lastWin1_q;
        bramAddr_d = bramAddr_q;
        bramDin_d  = bramDin_q;
        if (win0 | win1) begin
            lastWin1_d = win1;
            // If a write is in flight, the new one lands on the next slot.
            bramAddr_d = writing ? stepAddr(wrPtr_q) : wrPtr_q;
            bramDin_d  = win1 ? data1 : data0;
        end
        if (clear) begin
            wrPtr_d    = 32'd0;
            rdAddr_d   = 32'd0;
            count_d    = 16'd0;
            gnt0_d     = 1'b0;
            gnt1_d     = 1'b0;
            lastWin1_d = 1'b1;
        end
        empty_d = (count_d == 16'd0);
        full_d  = ({1'b0, count_d} == DEPTH);
        irq_d   = ({16'b0, count_d} >= IRQ_THRESH);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr_q    <= 32'd0;
            rdAddr_q   <= 32'd0;
            count_q    <= 16'd0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            lastWin1_q <= 1'b1;
            bramAddr_q <= 32'd0;
            bramDin_q  <= 32'd0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdAddr_q   <= rdAddr_d;
            count_q    <= count_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            lastWin1_q <= lastWin1_d;
            bramAddr_q <= bramAddr_d;
            bramDin_q  <= bramDin_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            irq_q      <= irq_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign bram_en   = writing;
    assign bram_we   = {4{writing}};
    assign bram_addr = bramAddr_q;
    assign bram_din  = bramDin_q;
    assign rd_addr   = rdAddr_q;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_out_buf_ctrl.sv
// Testbench for out_buf_ctrl with a 16-byte (4-word) buffer and IRQ_THRESH of 2.
// Expected BRAM writes are queued when the stimulus is issued. A negedge
// monitor pops one entry per write cycle and compares it with the DUT outputs.
module tb_out_buf_ctrl;

   typedef struct packed {
      logic        id;
      logic [31:0] addr;
      logic [31:0] data;
   } wrExp_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        enable;
   logic        clear;
   logic        req0, req1;
   logic [31:0] data0, data1;
   logic        gnt0, gnt1;
   logic        bram_en;
   logic [3:0]  bram_we;
   logic [31:0] bram_addr, bram_din;
   logic        rd_ack;
   logic [31:0] rd_addr;
   logic [15:0] count;
   logic        empty, full, irq;

   wrExp_t expQ[$];
   int     checks = 0;
   int     errors = 0;

   out_buf_ctrl #(
      .BRAM_MAX_ADDR(32'd16),
      .IRQ_THRESH   (32'd2)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .enable   (enable),
      .clear    (clear),
      .req0     (req0),
      .req1     (req1),
      .data0    (data0),
      .data1    (data1),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .bram_en  (bram_en),
      .bram_we  (bram_we),
      .bram_addr(bram_addr),
      .bram_din (bram_din),
      .rd_ack   (rd_ack),
      .rd_addr  (rd_addr),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .irq      (irq)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic r0, input logic [31:0] d0,
                                input logic r1, input logic [31:0] d1,
                                input logic ack, input logic clr);
      req0   = r0;
      data0  = d0;
      req1   = r1;
      data1  = d1;
      rd_ack = ack;
      clear  = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input logic id, input logic [31:0] a, input logic [31:0] d);
      wrExp_t e;
      e.id   = id;
      e.addr = a;
      e.data = d;
      expQ.push_back(e);
   endtask

   task automatic checkStatus(input string name, input logic [15:0] cnt,
                              input logic emp, input logic ful,
                              input logic irqExp, input logic [31:0] rd);
      checkOutput({name, "_count"}, 32'(count), 32'(cnt));
      checkOutput({name, "_empty"}, 32'(empty), 32'(emp));
      checkOutput({name, "_full"}, 32'(full), 32'(ful));
      checkOutput({name, "_irq"}, 32'(irq), 32'(irqExp));
      checkOutput({name, "_rd_addr"}, rd_addr, rd);
   endtask

   task automatic checkIdle(input string name, input logic [31:0] a, input logic [31:0] d);
      checkOutput({name, "_gnt_en"}, 32'({gnt0, gnt1, bram_en}), 32'd0);
      checkOutput({name, "_we"}, 32'(bram_we), 32'd0);
      checkOutput({name, "_addr"}, bram_addr, a);
      checkOutput({name, "_din"}, bram_din, d);
   endtask

   // Scoreboard monitor: every write cycle must match the oldest queued write.
   always @(negedge clk) begin
      wrExp_t e;
      if (resetn === 1'b1) begin
         checkOutput("gnt_vs_en", 32'(gnt0 | gnt1), 32'(bram_en));
         if (bram_en === 1'b1) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_write actual addr=%h din=%h required=no write",
                        bram_addr, bram_din);
            end else begin
               e = expQ.pop_front();
               checkOutput("wr_gnt", 32'({gnt1, gnt0}), e.id ? 32'd2 : 32'd1);
               checkOutput("wr_we", 32'(bram_we), 32'hF);
               checkOutput("wr_addr", bram_addr, e.addr);
               checkOutput("wr_din", bram_din, e.data);
            end
         end
      end
   end

   initial begin
      resetn = 1'b0;
      enable = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();
      checkIdle("reset", 32'h0, 32'h0);
      checkStatus("reset", 16'd0, 1'b1, 1'b0, 1'b0, 32'h0);
      resetn = 1'b1;
      tick();

      // Single write, then hold of address/data and a host ack.
      pushExp(1'b0, 32'h0, 32'hA5A5_0001);
      applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      checkOutput("single_gnt0", 32'(gnt0), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      checkStatus("single", 16'd1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkIdle("single_hold", 32'h0, 32'hA5A5_0001);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      checkStatus("ack1", 16'd0, 1'b1, 1'b0, 1'b0, 32'h4);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();
      checkStatus("clear1", 16'd0, 1'b1, 1'b0, 1'b0, 32'h0);

      // Contention: both held, grants alternate 0,1,0,1 and fill the buffer.
      pushExp(1'b0, 32'h0, 32'hC0C0_0000);
      pushExp(1'b1, 32'h4, 32'hC1C1_0001);
      pushExp(1'b0, 32'h8, 32'hC0C0_0002);
      pushExp(1'b1, 32'hC, 32'hC1C1_0003);
      applyStimulus(1'b1, 32'hC0C0_0000, 1'b1, 32'hC1C1_0001, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'hC0C0_0002, 1'b1, 32'hC1C1_0001, 1'b0, 1'b0);
      tick();
      checkStatus("cont_e2", 16'd1, 1'b0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'hC0C0_0002, 1'b1, 32'hC1C1_0003, 1'b0, 1'b0);
      tick();
      checkStatus("cont_irq_rise", 16'd2, 1'b0, 1'b0, 1'b1, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'hC1C1_0003, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      checkStatus("full", 16'd4, 1'b0, 1'b1, 1'b1, 32'h0);

      // Backpressure: a 5th request waits until an ack frees a word.
      pushExp(1'b0, 32'h0, 32'hE5E5_0005);
      applyStimulus(1'b1, 32'hE5E5_0005, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("bp_nogrant", 32'({gnt0, bram_en}), 32'd0);
      end
      applyStimulus(1'b1, 32'hE5E5_0005, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      checkOutput("bp_gnt0", 32'(gnt0), 32'd1);
      checkStatus("bp_ack", 16'd3, 1'b0, 1'b0, 1'b1, 32'h4);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      checkStatus("bp_refull", 16'd4, 1'b0, 1'b1, 1'b1, 32'h4);

      // Drain two words so rd_addr sits at the top slot.
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      tick();
      checkStatus("drain2", 16'd2, 1'b0, 1'b0, 1'b1, 32'hC);

      // Write commit and ack together: count holds, rd_addr wraps to 0.
      pushExp(1'b1, 32'h4, 32'hF6F6_0006);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'hF6F6_0006, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      checkStatus("simul", 16'd2, 1'b0, 1'b0, 1'b1, 32'h0);
      tick();
      checkStatus("irq_fall", 16'd1, 1'b0, 1'b0, 1'b0, 32'h4);
      tick();
      checkStatus("drain", 16'd0, 1'b1, 1'b0, 1'b0, 32'h8);
      tick();
      checkStatus("ack_empty", 16'd0, 1'b1, 1'b0, 1'b0, 32'h8);

      // clear in the decision cycle: no grant, state flushed.
      applyStimulus(1'b1, 32'h6767_0007, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();
      checkOutput("clr_nogrant", 32'({gnt0, gnt1, bram_en}), 32'd0);
      checkStatus("clr", 16'd0, 1'b1, 1'b0, 1'b0, 32'h0);
      pushExp(1'b0, 32'h0, 32'h6767_0007);
      applyStimulus(1'b1, 32'h6767_0007, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      checkStatus("post_clr", 16'd1, 1'b0, 1'b0, 1'b0, 32'h0);

      // Tie after requester 0 won: requester 1 goes first, then clear
      // during its write cycle flushes everything.
      pushExp(1'b1, 32'h4, 32'h8888_0008);
      applyStimulus(1'b1, 32'h9999_0009, 1'b1, 32'h8888_0008, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h9999_0009, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();
      checkOutput("clr_cancel", 32'({gnt0, gnt1, bram_en}), 32'd0);
      checkStatus("clr2", 16'd0, 1'b1, 1'b0, 1'b0, 32'h0);
      pushExp(1'b0, 32'h0, 32'h9999_0009);
      applyStimulus(1'b1, 32'h9999_0009, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      checkStatus("post_clr2", 16'd1, 1'b0, 1'b0, 1'b0, 32'h0);

      // Reset dropped in the middle of a write cycle.
      applyStimulus(1'b1, 32'hBBBB_000B, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      checkOutput("rst_pre_gnt0", 32'(gnt0), 32'd1);
      checkOutput("rst_pre_addr", bram_addr, 32'h4);
      resetn = 1'b0;
      #1;
      checkIdle("rst_mid", 32'h0, 32'h0);
      checkStatus("rst_mid", 16'd0, 1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      resetn = 1'b1;
      tick();
      tick();

      checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
